// File: rtl/aes_pkg.sv
// Shared types for the AES pipe scheduler: block/key words and scheduler FSM states.
package aes_pkg;

    typedef logic [127:0] aes_block_t;
    typedef logic [127:0] aes_key_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/aes_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; storage is reset so
// the head word reads as zero out of reset. DEPTH must be a power of 2.
module aes_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_rdata,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [AW-1:0]               r_wptr;
    logic [AW-1:0]               r_rptr;
    logic [CW-1:0]               r_count;
    logic                        w_do_push;
    logic                        w_do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/aes_pipe_sched.sv
// Round-robin scheduler and key controller in front of a shared 12-way AES encrypt pipe.
// Optional per-requester issue counters are enabled by defining AES_SCHED_STATS_EN.
module aes_pipe_sched
    import aes_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned RSP_DEPTH = 32,
    parameter int unsigned IDW       = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  aes_block_t [NREQ-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output aes_block_t              rsp_data,
    input  logic                    key_upd_valid,
    input  aes_key_t                key_upd_data,
    output logic                    key_upd_ack,
    output logic                    pipe_rst,
    output aes_key_t                pipe_key,
    output logic                    pipe_in_valid,
    output aes_block_t              pipe_in_data,
    input  logic                    pipe_out_valid,
    input  aes_block_t              pipe_out_data,
`ifdef AES_SCHED_STATS_EN
    output logic [NREQ-1:0][31:0]   stat_issued,
`endif
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned RW = IDW + 128;

    sched_state_e   r_state;
    sched_state_e   w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [2:0]     r_prst;
    logic           r_ack;
    logic           r_err;
    logic           r_pin_valid;
    aes_block_t     r_pin_data;
    aes_key_t       r_key;

    logic [IDW-1:0] w_gnt_id;
    logic           w_any;
    logic           w_key_req;
    logic           w_issue_ok;
    logic           w_xfer;
    logic           w_tag_empty;
    logic           w_ret;
    logic [CW-1:0]  w_tag_cnt;
    logic [CW-1:0]  w_rsp_cnt;
    logic [SW-1:0]  w_used;
    logic [IDW-1:0] w_tag_out;
    logic [RW-1:0]  w_rsp_out;

    function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int unsigned off);
        return IDW'((32'(base) + off) % NREQ);
    endfunction

    // Key request seen during the ack cycle is the one just serviced, not a new one.
    assign w_key_req  = key_upd_valid && !r_ack;
    assign w_used     = SW'(w_tag_cnt) + SW'(w_rsp_cnt);
    assign w_issue_ok = (r_state == RUN) && !pipe_rst && !w_key_req && (w_used < SW'(RSP_DEPTH));

    // First valid requester at or after the pointer.
    always_comb begin
        w_any    = 1'b0;
        w_gnt_id = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_any && req_valid[rot_idx(r_ptr, k)]) begin
                w_any    = 1'b1;
                w_gnt_id = rot_idx(r_ptr, k);
            end
        end
    end

    assign w_xfer    = w_any && w_issue_ok;
    assign req_ready = w_xfer ? (NREQ'(1) << w_gnt_id) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_key_req) w_state_nxt = DRAIN;
            DRAIN:   if (w_tag_cnt == '0) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_ptr       <= '0;
            r_prst      <= '1;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_pin_valid <= 1'b0;
            r_pin_data  <= '0;
            r_key       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prst      <= {r_prst[1:0], 1'b0};
            r_ack       <= (r_state == LOAD);
            r_err       <= r_err | (pipe_out_valid & w_tag_empty);
            r_pin_valid <= w_xfer;
            if (w_xfer) begin
                r_pin_data <= req_data[w_gnt_id];
                r_ptr      <= rot_idx(w_gnt_id, 1);
            end
            if (r_state == LOAD) begin
                r_key <= key_upd_data;
            end
        end
    end

    // Tag FIFO occupancy is the inflight count: one entry per issued, unreturned block.
    assign w_tag_empty = (w_tag_cnt == '0);
    assign w_ret       = pipe_out_valid && !w_tag_empty;

    aes_sync_fifo #(
        .WIDTH (IDW),
        .DEPTH (RSP_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_xfer),
        .i_wdata (w_gnt_id),
        .i_pop   (w_ret),
        .o_rdata (w_tag_out),
        .o_count (w_tag_cnt)
    );

    aes_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_ret),
        .i_wdata ({w_tag_out, pipe_out_data}),
        .i_pop   (rsp_valid & rsp_ready),
        .o_rdata (w_rsp_out),
        .o_count (w_rsp_cnt)
    );

`ifdef AES_SCHED_STATS_EN
    logic [NREQ-1:0][31:0] r_stat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat <= '0;
        end else if (w_xfer) begin
            r_stat[w_gnt_id] <= r_stat[w_gnt_id] + 32'd1;
        end
    end

    assign stat_issued = r_stat;
`endif

    assign rsp_valid     = (w_rsp_cnt != '0);
    assign rsp_id        = w_rsp_out[RW-1 -: IDW];
    assign rsp_data      = w_rsp_out[127:0];
    assign key_upd_ack   = r_ack;
    assign pipe_rst      = r_prst[2];
    assign pipe_key      = r_key;
    assign pipe_in_valid = r_pin_valid;
    assign pipe_in_data  = r_pin_data;
    assign busy          = !w_tag_empty || rsp_valid || (r_state != RUN);
    assign err           = r_err;

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Directed bench for aes_pipe_sched with a 12-stage pipe stub (ciphertext = data ^ key).
module tb_aes_pipe_sched;
    import aes_pkg::*;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned RSP_DEPTH = 32;
    localparam int unsigned IDW       = 2;
    localparam int unsigned PLAT      = 12;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    aes_block_t [NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [IDW-1:0]        rsp_id;
    aes_block_t            rsp_data;
    logic                  key_upd_valid = 1'b0;
    aes_key_t              key_upd_data = '0;
    logic                  key_upd_ack;
    logic                  pipe_rst;
    aes_key_t              pipe_key;
    logic                  pipe_in_valid;
    aes_block_t            pipe_in_data;
    logic                  pipe_out_valid;
    aes_block_t            pipe_out_data;
    logic                  busy;
    logic                  err;
`ifdef AES_SCHED_STATS_EN
    logic [NREQ-1:0][31:0] stat_issued;
`endif

    aes_pipe_sched #(.NREQ(NREQ), .RSP_DEPTH(RSP_DEPTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .key_upd_valid(key_upd_valid), .key_upd_data(key_upd_data), .key_upd_ack(key_upd_ack),
        .pipe_rst(pipe_rst), .pipe_key(pipe_key),
        .pipe_in_valid(pipe_in_valid), .pipe_in_data(pipe_in_data),
        .pipe_out_valid(pipe_out_valid), .pipe_out_data(pipe_out_data),
`ifdef AES_SCHED_STATS_EN
        .stat_issued(stat_issued),
`endif
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Pipe stub: fixed latency, synchronous clear on pipe_rst, optional forced output.
    logic       pv [PLAT];
    aes_block_t pd [PLAT];
    logic       f_valid = 1'b0;
    aes_block_t f_data = '0;

    always @(posedge clk) begin
        if (pipe_rst) begin
            for (int i = 0; i < PLAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= pipe_in_valid;
            pd[0] <= pipe_in_data ^ pipe_key;
            for (int i = 1; i < PLAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign pipe_out_valid = pv[PLAT-1] | f_valid;
    assign pipe_out_data  = f_valid ? f_data : pd[PLAT-1];

    typedef struct {
        logic [IDW-1:0] id;
        aes_block_t     data;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] exp_ready;
    } arb_vec_t;

    int       checks = 0;
    int       failures = 0;
    int       seq = 0;
    int       b_ptr = 0;
    int       rsp_seen = 0;
    aes_key_t cur_key = '0;
    exp_t     expq [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int p);
        logic [NREQ-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input logic [NREQ-1:0] v);
        req_valid = v;
        for (int i = 0; i < NREQ; i++)
            req_data[i] = {32'(i), 32'(seq), 64'h0123_4567_89AB_CDEF ^ {32'(seq), 32'(seq)}};
        seq++;
    endtask

    task automatic push_exp(input logic [NREQ-1:0] oh);
        exp_t e;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                e.id   = IDW'(i);
                e.data = req_data[i] ^ cur_key;
                expq.push_back(e);
                b_ptr = (i + 1) % NREQ;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || rsp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || rsp_valid) begin
            failures++;
            $display("FAIL %s: still busy=%0b rsp_valid=%0b after %0d cycles", name, busy, rsp_valid, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_key_ack"}, key_upd_ack, 0);
        chk({tag, "_pipe_key"}, pipe_key, 0);
        chk({tag, "_pin_valid"}, pipe_in_valid, 0);
        chk({tag, "_pin_data"}, pipe_in_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_pipe_rst"}, pipe_rst, 1);
    endtask

    // Release reset and verify the two-cycle pipe reset window blocks grants.
    task automatic release_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_req(4'hF);
        #1;
        chk({tag, "_prst_c1"}, pipe_rst, 1);
        chk({tag, "_nogrant_c1"}, req_ready, 0);
        @(negedge clk);
        #1;
        chk({tag, "_prst_c2"}, pipe_rst, 1);
        chk({tag, "_nogrant_c2"}, req_ready, 0);
        @(negedge clk);
        set_req(4'h0);
        #1;
        chk({tag, "_prst_c3"}, pipe_rst, 0);
    endtask

    // Response scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got id=%0d data=%h with nothing outstanding", rsp_id, rsp_data);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        arb_vec_t   tbl [15];
        aes_key_t   fips_key;
        aes_block_t fips_pt;
        int         n;
        int         early;
        int         grants;
        int         base;

        fips_key = 128'h000102030405060708090a0b0c0d0e0f;
        fips_pt  = 128'h00112233445566778899aabbccddeeff;

        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b0100, 4'b0100};
        tbl[6]  = '{4'b0101, 4'b0001};
        tbl[7]  = '{4'b0100, 4'b0100};
        tbl[8]  = '{4'b0000, 4'b0000};
        tbl[9]  = '{4'b1010, 4'b1000};
        tbl[10] = '{4'b1010, 4'b0010};
        tbl[11] = '{4'b1001, 4'b1000};
        tbl[12] = '{4'b0110, 4'b0010};
        tbl[13] = '{4'b0101, 4'b0100};
        tbl[14] = '{4'b0101, 4'b0001};

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst0");
        release_reset("rel0");

        // Round-robin grant table, including a one-cycle pulse on requester 0.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            set_req(tbl[k].valid);
            #1;
            chk($sformatf("arb_ready[%0d]", k), req_ready, tbl[k].exp_ready);
            if (k > 0)
                chk($sformatf("arb_pin_valid[%0d]", k), pipe_in_valid, (tbl[k-1].exp_ready != 0));
            push_exp(tbl[k].exp_ready);
        end
        @(negedge clk);
        set_req(4'h0);
        wait_idle("arb_idle");
        chk("arb_drained", expq.size(), 0);

        // Key update with 10 blocks inflight.
        base = rsp_seen;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            set_req(4'b0010);
            #1;
            chk($sformatf("key_fill[%0d]", k), req_ready, 4'b0010);
            push_exp(4'b0010);
        end
        @(negedge clk);
        set_req(4'b0010);
        key_upd_valid = 1'b1;
        key_upd_data  = fips_key;
        #1;
        chk("key_req_no_grant", req_ready, 0);
        n = 0; early = 0; grants = 0;
        while (!key_upd_ack && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (!key_upd_ack && pipe_key !== cur_key) early++;
            if (!key_upd_ack && req_ready != 0) grants++;
        end
        chk("key_ack_seen", key_upd_ack, 1);
        chk("key_no_grant_drain", grants, 0);
        chk("key_early_change", early, 0);
        chk("key_pipe_key", pipe_key, fips_key);
        chk("key_all_returned", rsp_seen - base, 10);
        cur_key = fips_key;
        set_req(4'h0);
        @(negedge clk);
        key_upd_valid = 1'b0;
        #1;
        chk("key_ack_single", key_upd_ack, 0);
        chk("key_consumed_idle", busy, 0);
        @(negedge clk);
        req_valid   = 4'b0100;
        req_data[2] = fips_pt;
        #1;
        chk("fips_grant", req_ready, 4'b0100);
        push_exp(4'b0100);
        @(negedge clk);
        set_req(4'h0);
        wait_idle("fips_idle");
        chk("fips_drained", expq.size(), 0);

        // Credit limit with the consumer stalled.
        rsp_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            logic [NREQ-1:0] e_rdy;
            @(negedge clk);
            set_req(4'hF);
            #1;
            e_rdy = (k < RSP_DEPTH) ? onehot(b_ptr) : '0;
            chk($sformatf("bp_ready[%0d]", k), req_ready, e_rdy);
            push_exp(e_rdy);
        end
        @(negedge clk);
        set_req(4'h0);
        #1;
        chk("bp_rsp_held", rsp_valid, 1);
        rsp_ready = 1'b1;
        wait_idle("bp_idle");
        chk("bp_drained", expq.size(), 0);

        // Spurious pipe output with no tag outstanding, one response buffered.
        rsp_ready = 1'b0;
        @(negedge clk);
        set_req(4'b0001);
        #1;
        chk("err_grant", req_ready, 4'b0001);
        push_exp(4'b0001);
        @(negedge clk);
        set_req(4'h0);
        n = 0;
        while (!(rsp_valid && busy && pv[PLAT-1] == 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("err_rsp_buffered", rsp_valid, 1);
        chk("err_pre", err, 0);
        @(negedge clk);
        f_valid = 1'b1;
        f_data  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        @(negedge clk);
        f_valid = 1'b0;
        #1;
        chk("err_set", err, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("err_sticky", err, 1);
        rsp_ready = 1'b1;
        wait_idle("err_idle");
        chk("err_fifo_unchanged", expq.size(), 0);
        chk("err_still_set", err, 1);

        // Reset with blocks inflight.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_req(4'b1000);
        end
        @(negedge clk);
        set_req(4'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst1");
        expq.delete();
        cur_key = '0;
        b_ptr   = 0;
        @(negedge clk);
        release_reset("rel1");
        @(negedge clk);
        set_req(4'hF);
        #1;
        chk("post_rst_ptr", req_ready, 4'b0001);
        push_exp(4'b0001);
        @(negedge clk);
        set_req(4'h0);
        wait_idle("post_rst_idle");
        repeat (20) @(negedge clk);
        chk("post_rst_drained", expq.size(), 0);
        chk("post_rst_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_pipe_sched.md
# aes_pipe_sched

Round-robin scheduler and key controller sharing one `aes_cipher_pipe` (12-way interleaved AES-128 encrypt pipe) between `NREQ` block requesters. It accepts one 128-bit plaintext block per cycle from the winning requester and tags it with the requester ID. It returns ciphertext in issue order through a credit-protected response FIFO, because the pipe output has no backpressure. It also sequences key changes by draining the pipe before loading a new key.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `RSP_DEPTH`, 32: response FIFO / tag FIFO depth; also the credit limit, power of 2
- `IDW`, `$clog2(NREQ)`: requester ID width
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-low
- `req_valid` in NREQ: per-requester block valid
- `req_data` in NREQ×128: per-requester plaintext
- `req_ready` out NREQ: one-hot grant; transfer when valid&ready
- `rsp_valid` out 1: ciphertext available
- `rsp_ready` in 1: consumer accepts
- `rsp_id` out IDW: originating requester
- `rsp_data` out 128: ciphertext
- `key_upd_valid` in 1: key change request, held until ack
- `key_upd_data` in 128: new key
- `key_upd_ack` out 1: one-cycle pulse, new key active
- `pipe_rst` out 1: active-high synchronous reset to pipe
- `pipe_key` out 128: key to pipe, stable between updates
- `pipe_in_valid` out 1: to pipe `data_in_valid`
- `pipe_in_data` out 128: to pipe `data_in`
- `pipe_out_valid` in 1: from pipe `data_out_valid`
- `pipe_out_data` in 128: from pipe `data_out`
- `busy` out 1: inflight != 0 or FIFO not empty or FSM != RUN
- `err` out 1: sticky; pipe output arrived with tag FIFO empty

## Operation
- Credits: `inflight` (issued, not returned) + `rsp_cnt` (FIFO occupancy) ≤ RSP_DEPTH at all times.
- Issue is allowed when FSM=RUN and `inflight + rsp_cnt < RSP_DEPTH`.
- Arbiter: round-robin. The pointer starts at 0 and moves to grant+1 (mod NREQ) after each transfer. `req_ready` is asserted only for the selected valid requester. It is combinational from `req_valid`, pointer and issue-allowed.
- On transfer: register `req_data` to `pipe_in_data`, pulse `pipe_in_valid`, push granted ID into the tag FIFO, increment `inflight`.
- On `pipe_out_valid`: pop the tag FIFO, push {tag, data} into the response FIFO, decrement `inflight`. This push cannot overflow, by the credit rule.
- If `pipe_out_valid` arrives with the tag FIFO empty: set `err`, drop the data, leave `inflight` unchanged.
- Simultaneous issue and return in one cycle: `inflight` is unchanged; both FIFOs push and pop legally.
- FSM RUN: on `key_upd_valid`, go to DRAIN; grants stop the same cycle.
- FSM DRAIN: when `inflight==0`, go to LOAD. The response FIFO need not be empty.
- FSM LOAD: `pipe_key <= key_upd_data`, pulse `key_upd_ack`, go to RUN.
- No block issued under the old key returns after the ack.
- `key_upd_valid` asserted during LOAD's ack cycle is consumed; the requester must drop it.

## Timing
- Grant to `pipe_in_valid`: 1 cycle. Throughput is 1 block/cycle.
- Response FIFO is first-word-fall-through. Pipe return to `rsp_valid`: 1 cycle.
- Key update: ≥ 2 cycles after request (DRAIN min 1 cycle, LOAD 1 cycle), plus pipe drain time.
- Reset values (rst low, async):
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0
  - `key_upd_ack`=0, `pipe_key`=0, `pipe_in_valid`=0, `pipe_in_data`=0
  - `busy`=0, `err`=0, FSM=RUN, pointer=0, counters=0
- `pipe_rst` is 1 during reset and for 2 cycles after deassertion. No grants while `pipe_rst`=1.
- Reset mid-operation discards all inflight and buffered blocks.

## Configuration
- `AES_SCHED_STATS_EN` defined: adds per-requester 32-bit wrapping issued-block counters, cleared by reset, as output `stat_issued` [NREQ×32].
- `AES_SCHED_STATS_EN` undefined: no `stat_issued` port and no counters.

## Structure
- Package `aes_pkg`: `aes_block_t` (logic [127:0]), `aes_key_t`, FSM enum `sched_state_e` {RUN, DRAIN, LOAD}.
- One sub-module: `aes_sync_fifo` (parameterised width/depth, FWFT, count output), instanced twice for the tag FIFO and the response FIFO.

## Test plan
- NREQ=4, all requesters valid continuously, `rsp_ready`=1: grant order is 0,1,2,3,0…; `rsp_id` sequence matches; one response per cycle in steady state.
- `rsp_ready`=0 with RSP_DEPTH=32: exactly 32 blocks issued, then `req_ready` stays 0 until `rsp_ready`=1; no data lost.
- Key update with 10 blocks inflight: no grants from the request cycle on; `pipe_key` changes only after all 10 return; `key_upd_ack` pulses once; FIPS-197 vector under the new key is correct.
- Only requester 2 valid, with a single-cycle pulse on requester 0: no starvation; requester 0 is granted within NREQ cycles.
- Forced `pipe_out_valid` with the tag FIFO empty: `err`=1 and stays set until reset; FIFO contents are unchanged.
- Assert reset with 5 blocks inflight: all outputs return to their reset values immediately; `pipe_rst` high for 2 cycles after release; no stale response appears.
